// File: rtl/dl2_mem_responder.sv
// dl2_mem_responder: block-oriented memory model that answers an L2 cache.
// Writes arrive as beats of BLOCK_BITS/SUBBLOCKS bits. A read request is
// answered RD_LAT cycles later with a burst of SUBBLOCKS beats. Flush requests
// are acknowledged once the responder is back in IDLE.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   addr               block-aligned byte address (held through a write burst)
//   en                 single-cycle read request
//   we, din_strobe,din write beat valid, beat index, beat data
//   dready, dout_strobe, dout   read beat valid, beat index, beat data
//   acc_r, acc_w       responder idle and able to take a read / new write burst
//   flush_in           flush request pulse
//   flush_done         one-cycle flush completion pulse
//   proto_err          sticky protocol-violation flag
`timescale 1ns/1ps
module dl2_mem_responder #(
    parameter int ADDR_BITS       = 32,
    parameter int BLOCK_BITS      = 512,
    parameter int SUBBLOCKS       = 4,
    parameter int SUB_LOG2        = 2,
    parameter int MEM_BLOCKS_LOG2 = 10,
    parameter int RD_LAT          = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_BITS-1:0]             addr,
    input  logic                             en,
    input  logic                             we,
    input  logic [SUB_LOG2-1:0]              din_strobe,
    input  logic [BLOCK_BITS/SUBBLOCKS-1:0]  din,
    output logic [SUB_LOG2-1:0]              dout_strobe,
    output logic [BLOCK_BITS/SUBBLOCKS-1:0]  dout,
    output logic                             dready,
    output logic                             acc_r,
    output logic                             acc_w,
    input  logic                             flush_in,
    output logic                             flush_done,
    output logic                             proto_err
);
    localparam int BEAT_W = BLOCK_BITS / SUBBLOCKS;
    localparam int OFFS   = $clog2(BLOCK_BITS / 8);
    localparam int WORDS  = (2 ** MEM_BLOCKS_LOG2) * SUBBLOCKS;
    localparam int IDX_W  = MEM_BLOCKS_LOG2 + SUB_LOG2;
    localparam logic [SUB_LOG2-1:0] LAST = SUB_LOG2'(SUBBLOCKS - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

    state_t                     state, nxt;
    logic                       ready;
    logic                       flush_pend;
    logic [MEM_BLOCKS_LOG2-1:0] blk_q;
    logic [MEM_BLOCKS_LOG2-1:0] req_blk;
    logic [3:0]                 wait_cnt;
    logic [BEAT_W-1:0]          mem [WORDS];

    logic                       wr_fire, rd_fire, last_wr, viol;
    logic                       wait_end, burst_end;
    logic [SUB_LOG2-1:0]        nxt_beat;
    logic [IDX_W-1:0]           wr_idx, rd_idx;
    logic                       unused_addr;

    // Only the block-index field of the address selects storage; the byte
    // offset and the bits above the array size are don't-care.
    assign req_blk     = addr[OFFS +: MEM_BLOCKS_LOG2];
    assign unused_addr = ^{addr[ADDR_BITS-1:OFFS+MEM_BLOCKS_LOG2], addr[OFFS-1:0]};

    // ready is a registered "state is IDLE"; it stays low for the first cycle
    // after reset so requests are only taken once the responder has settled.
    assign acc_r = ready;
    assign acc_w = ready;

    always_comb begin
        wr_fire   = we && ((state == IDLE && ready) || state == WR_BURST);
        rd_fire   = en && !we && state == IDLE && ready;
        last_wr   = wr_fire && (din_strobe == LAST);
        wait_end  = (state == RD_WAIT) && (wait_cnt == 4'd0);
        burst_end = (state == RD_BURST) && (dout_strobe == LAST);
        viol      = (en && we && state == IDLE && ready)
                 || (en && state != IDLE)
                 || (we && (state == RD_WAIT || state == RD_BURST));
        nxt_beat  = dout_strobe + SUB_LOG2'(1);
        wr_idx    = {(state == IDLE) ? req_blk : blk_q, din_strobe};
        rd_idx    = {blk_q, wait_end ? {SUB_LOG2{1'b0}} : nxt_beat};

        nxt = state;
        case (state)
            IDLE: begin
                if (wr_fire && !last_wr) nxt = WR_BURST;
                else if (rd_fire)        nxt = RD_WAIT;
            end
            RD_WAIT:  if (wait_end)  nxt = RD_BURST;
            RD_BURST: if (burst_end) nxt = IDLE;
            WR_BURST: if (last_wr)   nxt = IDLE;
            default:                 nxt = IDLE;
        endcase
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_idx] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b0;
            dready      <= 1'b0;
            dout        <= '0;
            dout_strobe <= '0;
            flush_done  <= 1'b0;
            flush_pend  <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state     <= nxt;
            ready     <= (nxt == IDLE);
            proto_err <= proto_err | viol;

            // A flush seen while busy is held until the return to IDLE; all
            // pulses collected during one busy period give a single done.
            flush_done <= (flush_in && state == IDLE)
                       || (state != IDLE && nxt == IDLE && (flush_pend || flush_in));
            flush_pend <= (state != IDLE) && (nxt != IDLE) && (flush_pend || flush_in);

            if (rd_fire || (wr_fire && state == IDLE)) blk_q <= req_blk;

            // Counter runs RD_LAT-1 cycles so the first beat register loads on
            // the edge that ends cycle t+RD_LAT-1.
            if (rd_fire)               wait_cnt <= 4'(RD_LAT - 2);
            else if (state == RD_WAIT) wait_cnt <= wait_cnt - 4'd1;

            if (wait_end) begin
                dready      <= 1'b1;
                dout        <= mem[rd_idx];
                dout_strobe <= '0;
            end else if (burst_end) begin
                dready <= 1'b0;
                dout   <= '0;
            end else if (state == RD_BURST) begin
                dout        <= mem[rd_idx];
                dout_strobe <= nxt_beat;
            end
        end
    end
endmodule
